// File: rtl/game_pkg.sv
// Shared types and constants for the brick-breaker game sequencer.
// Holds the phase encoding, overlay colours and counter widths.
package game_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_MISS    = 3'd3,
        ST_OVER    = 3'd4,
        ST_WIN     = 3'd5
    } game_state_t;

    localparam int SCORE_W  = 16;
    localparam int BRICKS_W = 6;
    localparam int LIVES_W  = 2;
    localparam int FRAME_W  = 8;

    localparam logic [23:0] COLOR_ATTRACT = 24'h000040;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;
    localparam logic [23:0] COLOR_MISS    = 24'h200000;
    localparam logic [23:0] COLOR_OVER    = 24'h800000;
    localparam logic [23:0] COLOR_WIN     = 24'h008000;

    function automatic logic [23:0] state_color(input game_state_t s);
        case (s)
            ST_ATTRACT: state_color = COLOR_ATTRACT;
            ST_MISS:    state_color = COLOR_MISS;
            ST_OVER:    state_color = COLOR_OVER;
            ST_WIN:     state_color = COLOR_WIN;
            default:    state_color = COLOR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for an active-low push button followed by a
// registered falling-edge detector; one pulse per press, three edges after the fall.
module button_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;

    // Synchronizer chain reset to "released" so reset never looks like a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_prev & ~r_sync2;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/game_controller.sv
// Top-level game phase sequencer: gates the ball, commands serve and brick
// restore, and keeps lives, score and bricks remaining.
module game_controller
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int NUM_BRICKS   = 40,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 90
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_frame_tick,
    input  logic                i_start_n,
    input  logic                i_brick_hit,
    input  logic                i_ball_lost,
    output logic [2:0]          o_game_state,
    output logic                o_ball_run,
    output logic                o_ball_serve,
    output logic                o_bricks_reset,
    output logic [LIVES_W-1:0]  o_lives,
    output logic [SCORE_W-1:0]  o_score,
    output logic [BRICKS_W-1:0] o_bricks_left,
    output logic [23:0]         o_overlay_color
);

    localparam logic [LIVES_W-1:0]  LIVES_INIT  = LIVES_W'(LIVES);
    localparam logic [BRICKS_W-1:0] BRICKS_INIT = BRICKS_W'(NUM_BRICKS);
    localparam logic [FRAME_W-1:0]  SERVE_LAST  = FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_W-1:0]  MISS_LAST   = FRAME_W'(MISS_FRAMES - 1);

    logic w_start_press;

    game_state_t         r_state;
    logic [FRAME_W-1:0]  r_frame;
    logic [LIVES_W-1:0]  r_lives;
    logic [SCORE_W-1:0]  r_score;
    logic [BRICKS_W-1:0] r_bricks;
    logic                r_ball_run;
    logic                r_ball_serve;
    logic                r_bricks_reset;
    logic [23:0]         r_overlay;

    game_state_t         w_state_next;
    logic [FRAME_W-1:0]  w_frame_next;
    logic [LIVES_W-1:0]  w_lives_next;
    logic [SCORE_W-1:0]  w_score_next;
    logic [BRICKS_W-1:0] w_bricks_next;
    logic                w_serve_next;
    logic                w_bricks_reset_next;

    button_sync_edge u_start (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_start_n),
        .o_press (w_start_press)
    );

    // Next-state and datapath update for every phase.
    always_comb begin
        w_state_next        = r_state;
        w_frame_next        = r_frame;
        w_lives_next        = r_lives;
        w_score_next        = r_score;
        w_bricks_next       = r_bricks;
        w_serve_next        = 1'b0;
        w_bricks_reset_next = 1'b0;
        case (r_state)
            ST_ATTRACT, ST_OVER, ST_WIN: begin
                if (w_start_press) begin
                    w_state_next        = ST_SERVE;
                    w_serve_next        = 1'b1;
                    w_bricks_reset_next = 1'b1;
                    w_lives_next        = LIVES_INIT;
                    w_score_next        = {SCORE_W{1'b0}};
                    w_bricks_next       = BRICKS_INIT;
                    w_frame_next        = {FRAME_W{1'b0}};
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_SERVE: begin
                if (i_frame_tick && (r_frame == SERVE_LAST)) begin
                    w_state_next = ST_PLAY;
                    w_frame_next = {FRAME_W{1'b0}};
                end else if (i_frame_tick) begin
                    w_frame_next = r_frame + 8'd1;
                end else begin
                    w_frame_next = r_frame;
                end
            end
            ST_PLAY: begin
                if (i_brick_hit && (r_bricks != {BRICKS_W{1'b0}})) begin
                    w_bricks_next = r_bricks - 6'd1;
                    w_score_next  = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
                end else begin
                    w_bricks_next = r_bricks;
                end
                // A hit that clears the field beats a simultaneous loss.
                if (i_brick_hit && (r_bricks == 6'd1)) begin
                    w_state_next = ST_WIN;
                end else if (i_ball_lost) begin
                    w_lives_next = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                    w_state_next = (r_lives <= 2'd1) ? ST_OVER : ST_MISS;
                    w_frame_next = {FRAME_W{1'b0}};
                end else begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_MISS: begin
                if (i_frame_tick && (r_frame == MISS_LAST)) begin
                    w_state_next = ST_SERVE;
                    w_serve_next = 1'b1;
                    w_frame_next = {FRAME_W{1'b0}};
                end else if (i_frame_tick) begin
                    w_frame_next = r_frame + 8'd1;
                end else begin
                    w_frame_next = r_frame;
                end
            end
            default: begin
                w_state_next = ST_ATTRACT;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_ATTRACT;
            r_frame        <= {FRAME_W{1'b0}};
            r_lives        <= LIVES_INIT;
            r_score        <= {SCORE_W{1'b0}};
            r_bricks       <= BRICKS_INIT;
            r_ball_run     <= 1'b0;
            r_ball_serve   <= 1'b0;
            r_bricks_reset <= 1'b0;
            r_overlay      <= COLOR_BLACK;
        end else begin
            r_state        <= w_state_next;
            r_frame        <= w_frame_next;
            r_lives        <= w_lives_next;
            r_score        <= w_score_next;
            r_bricks       <= w_bricks_next;
            r_ball_run     <= (w_state_next == ST_PLAY);
            r_ball_serve   <= w_serve_next;
            r_bricks_reset <= w_bricks_reset_next;
            r_overlay      <= state_color(w_state_next);
        end
    end

    assign o_game_state    = r_state;
    assign o_ball_run      = r_ball_run;
    assign o_ball_serve    = r_ball_serve;
    assign o_bricks_reset  = r_bricks_reset;
    assign o_lives         = r_lives;
    assign o_score         = r_score;
    assign o_bricks_left   = r_bricks;
    assign o_overlay_color = r_overlay;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller with hand-computed expectations.
module tb_game_controller;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_frame_tick = 1'b0;
    logic        i_start_n = 1'b1;
    logic        i_brick_hit = 1'b0;
    logic        i_ball_lost = 1'b0;
    logic [2:0]  o_game_state;
    logic        o_ball_run;
    logic        o_ball_serve;
    logic        o_bricks_reset;
    logic [1:0]  o_lives;
    logic [15:0] o_score;
    logic [5:0]  o_bricks_left;
    logic [23:0] o_overlay_color;

    int n_checks = 0;
    int n_fail   = 0;
    int serve_cnt;
    int brst_cnt;

    localparam logic [2:0] S_ATTRACT = 3'd0;
    localparam logic [2:0] S_SERVE   = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_MISS    = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;
    localparam logic [2:0] S_WIN     = 3'd5;

    game_controller dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_frame_tick    (i_frame_tick),
        .i_start_n       (i_start_n),
        .i_brick_hit     (i_brick_hit),
        .i_ball_lost     (i_ball_lost),
        .o_game_state    (o_game_state),
        .o_ball_run      (o_ball_run),
        .o_ball_serve    (o_ball_serve),
        .o_bricks_reset  (o_bricks_reset),
        .o_lives         (o_lives),
        .o_score         (o_score),
        .o_bricks_left   (o_bricks_left),
        .o_overlay_color (o_overlay_color)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
            if (o_ball_serve) serve_cnt++;
            if (o_bricks_reset) brst_cnt++;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            i_frame_tick = 1'b1;
            step(1);
            i_frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            i_brick_hit = 1'b1;
            step(1);
            i_brick_hit = 1'b0;
            step(1);
        end
    endtask

    task automatic lose();
        i_ball_lost = 1'b1;
        step(1);
        i_ball_lost = 1'b0;
    endtask

    // Hold start for 100 cycles: state changes on the 4th edge, exactly one pulse each.
    task automatic press_start(input logic [2:0] prior);
        serve_cnt = 0;
        brst_cnt  = 0;
        i_start_n = 1'b0;
        step(3);
        check("start_latency_state", 32'(o_game_state), 32'(prior));
        step(1);
        check("start_state", 32'(o_game_state), 32'(S_SERVE));
        check("start_serve_pulse", 32'(o_ball_serve), 32'd1);
        check("start_brst_pulse", 32'(o_bricks_reset), 32'd1);
        check("start_lives", 32'(o_lives), 32'd3);
        check("start_bricks", 32'(o_bricks_left), 32'd40);
        check("start_score", 32'(o_score), 32'd0);
        step(96);
        check("start_serve_count", 32'(serve_cnt), 32'd1);
        check("start_brst_count", 32'(brst_cnt), 32'd1);
        i_start_n = 1'b1;
        step(4);
        check("release_state", 32'(o_game_state), 32'(S_SERVE));
    endtask

    initial begin
        serve_cnt = 0;
        brst_cnt  = 0;
        step(2);
        check("rst_state", 32'(o_game_state), 32'(S_ATTRACT));
        check("rst_lives", 32'(o_lives), 32'd3);
        check("rst_score", 32'(o_score), 32'd0);
        check("rst_bricks", 32'(o_bricks_left), 32'd40);
        check("rst_run", 32'(o_ball_run), 32'd0);
        check("rst_overlay", o_overlay_color, 32'h0);
        i_rst = 1'b0;
        step(1);
        check("attract_overlay", o_overlay_color, 32'h000040);

        press_start(S_ATTRACT);
        check("serve_overlay", o_overlay_color, 32'h0);
        frames(59);
        check("serve_59", 32'(o_game_state), 32'(S_SERVE));
        check("serve_59_run", 32'(o_ball_run), 32'd0);
        frames(1);
        check("serve_60", 32'(o_game_state), 32'(S_PLAY));
        check("play_run", 32'(o_ball_run), 32'd1);

        hits(39);
        check("hit39_score", 32'(o_score), 32'd39);
        check("hit39_bricks", 32'(o_bricks_left), 32'd1);
        check("hit39_state", 32'(o_game_state), 32'(S_PLAY));
        hits(1);
        check("win_state", 32'(o_game_state), 32'(S_WIN));
        check("win_score", 32'(o_score), 32'd40);
        check("win_bricks", 32'(o_bricks_left), 32'd0);
        check("win_overlay", o_overlay_color, 32'h008000);
        check("win_run", 32'(o_ball_run), 32'd0);

        press_start(S_WIN);
        lose();
        step(1);
        check("serve_lost_ignored", 32'(o_lives), 32'd3);
        frames(60);
        check("play2_state", 32'(o_game_state), 32'(S_PLAY));

        lose();
        check("miss1_state", 32'(o_game_state), 32'(S_MISS));
        check("miss1_lives", 32'(o_lives), 32'd2);
        check("miss1_run", 32'(o_ball_run), 32'd0);
        check("miss1_overlay", o_overlay_color, 32'h200000);
        serve_cnt = 0;
        frames(89);
        check("miss_89", 32'(o_game_state), 32'(S_MISS));
        frames(1);
        check("miss_90", 32'(o_game_state), 32'(S_SERVE));
        check("miss_serve_pulse", 32'(serve_cnt), 32'd1);
        frames(60);
        check("miss1_replay", 32'(o_game_state), 32'(S_PLAY));

        lose();
        check("miss2_lives", 32'(o_lives), 32'd1);
        frames(150);
        check("miss2_replay", 32'(o_game_state), 32'(S_PLAY));
        check("miss2_run", 32'(o_ball_run), 32'd1);

        lose();
        check("over_state", 32'(o_game_state), 32'(S_OVER));
        check("over_lives", 32'(o_lives), 32'd0);
        check("over_run", 32'(o_ball_run), 32'd0);
        check("over_overlay", o_overlay_color, 32'h800000);
        hits(2);
        frames(150);
        check("over_hold", 32'(o_game_state), 32'(S_OVER));
        check("over_score", 32'(o_score), 32'd0);

        press_start(S_OVER);
        frames(60);
        hits(39);
        i_brick_hit = 1'b1;
        i_ball_lost = 1'b1;
        step(1);
        i_brick_hit = 1'b0;
        i_ball_lost = 1'b0;
        check("both_last_state", 32'(o_game_state), 32'(S_WIN));
        check("both_last_lives", 32'(o_lives), 32'd3);
        check("both_last_bricks", 32'(o_bricks_left), 32'd0);

        press_start(S_WIN);
        frames(60);
        hits(7);
        check("pre_rst_score", 32'(o_score), 32'd7);
        i_rst = 1'b1;
        #1;
        check("arst_state", 32'(o_game_state), 32'(S_ATTRACT));
        check("arst_score", 32'(o_score), 32'd0);
        check("arst_run", 32'(o_ball_run), 32'd0);
        check("arst_bricks", 32'(o_bricks_left), 32'd40);
        check("arst_overlay", o_overlay_color, 32'h0);
        step(1);
        i_rst = 1'b0;
        hits(3);
        check("attract_hits_score", 32'(o_score), 32'd0);
        check("attract_hits_state", 32'(o_game_state), 32'(S_ATTRACT));

        press_start(S_ATTRACT);
        frames(60);
        hits(35);
        check("hit35_bricks", 32'(o_bricks_left), 32'd5);
        i_brick_hit = 1'b1;
        i_ball_lost = 1'b1;
        step(1);
        i_brick_hit = 1'b0;
        i_ball_lost = 1'b0;
        check("both_mid_state", 32'(o_game_state), 32'(S_MISS));
        check("both_mid_bricks", 32'(o_bricks_left), 32'd4);
        check("both_mid_lives", 32'(o_lives), 32'd2);
        check("both_mid_score", 32'(o_score), 32'd36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
